chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder_pkg.sv | 31 +++
 rtl/chunked_adder_full_adder.sv | 13 +
 rtl/chunked_adder.sv | 163 ++++++++++++++++
 tb/tb_chunked_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked (multi-cycle, CHUNK bits per cycle) adder.
package chunked_adder_pkg;

    // Default geometry of the adder.
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Controller states: accept operands, ripple chunks, present result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of chunk cycles needed for one operation.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; kept at least one bit so NCHUNK == 1 still elaborates.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/chunked_adder_full_adder.sv
// One-bit full adder; the chunk adder is a ripple chain of these cells.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a valid/ready handshake on both the operand and result sides.
// WIDTH must be an integer multiple of CHUNK.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_sub,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_S,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    // Controller and working registers
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtract
    logic [WIDTH-1:0] s_q, s_d;      // partial sum, filled chunk by chunk
    logic             c_q, c_d;      // carry between chunks

    // Result registers, only updated on entry to DONE
    logic [WIDTH-1:0] res_s_q, res_s_d;
    logic             res_c_q, res_c_d;
    logic             res_ovf_q, res_ovf_d;

    // Datapath for the current chunk
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] sum_chunk_s;
    logic [CHUNK:0]   carry_s;
    logic [WIDTH-1:0] s_next_s;

    // Select chunk cnt_q of both operands (one-hot OR, so no priority logic).
    always_comb begin
        a_chunk_s = '0;
        b_chunk_s = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            a_chunk_s = a_chunk_s | ((cnt_q == CNT_W'(k)) ? a_q[k*CHUNK +: CHUNK] : '0);
            b_chunk_s = b_chunk_s | ((cnt_q == CNT_W'(k)) ? b_q[k*CHUNK +: CHUNK] : '0);
        end
    end

    // Ripple chain over one chunk, seeded by the registered inter-chunk carry.
    assign carry_s[0] = c_q;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .i_a (a_chunk_s[i]),
            .i_b (b_chunk_s[i]),
            .i_c (carry_s[i]),
            .o_s (sum_chunk_s[i]),
            .o_c (carry_s[i+1])
        );
    end

    // Merge the freshly computed chunk into the partial sum.
    always_comb begin
        s_next_s = s_q;
        for (int k = 0; k < NCHUNK; k++) begin
            s_next_s[k*CHUNK +: CHUNK] = (cnt_q == CNT_W'(k)) ? sum_chunk_s
                                                               : s_q[k*CHUNK +: CHUNK];
        end
    end

    // Next-state and next-register logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        res_s_d   = res_s_q;
        res_c_d   = res_c_q;
        res_ovf_d = res_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    // Subtract is A + ~B + 1; a borrow-in removes that +1.
                    a_d     = i_A;
                    b_d     = i_sub ? ~i_B : i_B;
                    c_d     = i_carry ^ i_sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d = s_next_s;
                c_d = carry_s[CHUNK];
                if (cnt_q == LAST_CNT) begin
                    res_s_d   = s_next_s;
                    res_c_d   = carry_s[CHUNK];
                    res_ovf_d = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], s_next_s[WIDTH-1]);
                    state_d   = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working and result registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= 1'b0;
            res_s_q   <= '0;
            res_c_q   <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            res_s_q   <= res_s_d;
            res_c_q   <= res_c_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_S     = res_s_q;
    assign o_carry = res_c_q;
    assign o_ovf   = res_ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed-vector bench for chunked_adder (CHUNK=4 and CHUNK=16 instances).
module tb_chunked_adder;

    logic        clk;
    logic        rst_n;

    // CHUNK=4 instance
    logic        valid, ready_o, sub, cin, valid_o, ready;
    logic [15:0] a, b, s_o;
    logic        carry_o, ovf_o;

    // CHUNK=16 instance
    logic        w_valid, w_ready_o, w_sub, w_cin, w_valid_o, w_ready;
    logic [15:0] w_a, w_b, w_s_o;
    logic        w_carry_o, w_ovf_o;

    int          chk_cnt;
    int          err_cnt;
    logic [15:0] last_s;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .o_ready (ready_o),
        .i_A     (a),
        .i_B     (b),
        .i_sub   (sub),
        .i_carry (cin),
        .o_valid (valid_o),
        .i_ready (ready),
        .o_S     (s_o),
        .o_carry (carry_o),
        .o_ovf   (ovf_o)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut_w (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_valid),
        .o_ready (w_ready_o),
        .i_A     (w_a),
        .i_B     (w_b),
        .i_sub   (w_sub),
        .i_carry (w_cin),
        .o_valid (w_valid_o),
        .i_ready (w_ready),
        .o_S     (w_s_o),
        .o_carry (w_carry_o),
        .o_ovf   (w_ovf_o)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand set to the CHUNK=4 instance and check the result.
    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_sub, input logic op_cin,
                          input logic [15:0] exp_s, input logic exp_c, input logic exp_ovf);
        int cyc;
        @(negedge clk);
        check_eq({tag, "_ready"}, 32'(ready_o), 32'(1'b1));
        a = op_a; b = op_b; sub = op_sub; cin = op_cin; valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after capture; they must not affect the result.
        valid = 1'b0; a = ~op_a; b = ~op_b; sub = ~op_sub; cin = ~op_cin;
        cyc = 0;
        while (valid_o !== 1'b1 && cyc < 20) begin
            check_eq({tag, "_hold_prev"}, 32'(s_o), 32'(last_s));
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
        check_eq({tag, "_s"},       32'(s_o),     32'(exp_s));
        check_eq({tag, "_carry"},   32'(carry_o), 32'(exp_c));
        check_eq({tag, "_ovf"},     32'(ovf_o),   32'(exp_ovf));
        last_s = exp_s;
    endtask

    // Accept the presented result and confirm return to IDLE.
    task automatic finish_op(input string tag);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check_eq({tag, "_idle_ready"}, 32'(ready_o), 32'(1'b1));
        check_eq({tag, "_idle_valid"}, 32'(valid_o), 32'(1'b0));
    endtask

    initial begin
        int cyc;
        chk_cnt = 0; err_cnt = 0; last_s = 16'h0000;
        valid = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; cin = 1'b0; ready = 1'b0;
        w_valid = 1'b0; w_a = 16'h0000; w_b = 16'h0000; w_sub = 1'b0; w_cin = 1'b0; w_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ready_o), 32'(1'b1));
        check_eq("rst_valid", 32'(valid_o), 32'(1'b0));
        check_eq("rst_s",     32'(s_o),     32'h0);
        check_eq("rst_carry", 32'(carry_o), 32'(1'b0));
        check_eq("rst_ovf",   32'(ovf_o),   32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Carry out of the top, no signed overflow
        run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Hold DONE for three cycles while poking the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = ~valid; a = 16'h1357 + 16'(i); b = 16'h2468; sub = ~sub;
            @(posedge clk);
            #1;
            check_eq("done_hold_s",     32'(s_o),     32'h0000);
            check_eq("done_hold_carry", 32'(carry_o), 32'(1'b1));
            check_eq("done_hold_ready", 32'(ready_o), 32'(1'b0));
            check_eq("done_hold_valid", 32'(valid_o), 32'(1'b1));
        end
        valid = 1'b0;
        finish_op("add_ffff_1");

        run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        finish_op("add_7fff_1");

        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        finish_op("sub_5_7");

        run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        finish_op("sub_8000_1");

        // Negative overflow with carry out; borrow-in on subtract
        run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        finish_op("add_8000_8000");
        run_op("sub_10_3_bin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        finish_op("sub_10_3_bin");

        // Abort a transaction after two RUN cycles
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(valid_o), 32'(1'b0));
        check_eq("abort_ready", 32'(ready_o), 32'(1'b1));
        check_eq("abort_s",     32'(s_o),     32'h0);
        last_s = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_1234_1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        finish_op("add_1234_1111");

        // Single-chunk instance: one-cycle latency
        @(negedge clk);
        check_eq("w_ready", 32'(w_ready_o), 32'(1'b1));
        w_a = 16'hFFFF; w_b = 16'hFFFF; w_sub = 1'b0; w_cin = 1'b1; w_valid = 1'b1;
        @(posedge clk);
        #1;
        w_valid = 1'b0; w_a = 16'h0000; w_b = 16'h0000; w_cin = 1'b0;
        cyc = 0;
        while (w_valid_o !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("w_latency", 32'(cyc),       32'd1);
        check_eq("w_s",       32'(w_s_o),     32'hFFFF);
        check_eq("w_carry",   32'(w_carry_o), 32'(1'b1));
        check_eq("w_ovf",     32'(w_ovf_o),   32'(1'b0));
        @(negedge clk);
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        w_ready = 1'b0;
        check_eq("w_idle_ready", 32'(w_ready_o), 32'(1'b1));

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
